// File: rtl/connect4_defs.sv
// rtl/connect4_defs.sv - shared encodings for the 4x4 Connect4 datapath
package connect4_defs;

  localparam logic [1:0] ST_PLAY  = 2'b00;
  localparam logic [1:0] ST_P1WIN = 2'b01;
  localparam logic [1:0] ST_P2WIN = 2'b10;
  localparam logic [1:0] ST_TIE   = 2'b11;

  localparam int BOARD_ROWS = 4;
  localparam int BOARD_COLS = 4;

  localparam logic P1 = 1'b0;
  localparam logic P2 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DROP,
    S_EVAL,
    S_GAME_OVER
  } drop_state_t;

endpackage

// File: rtl/column_scan.sv
// rtl/column_scan.sv - lowest empty row and full flag for one board column
import connect4_defs::*;

module column_scan (
  input  logic [15:0] board,
  input  logic [1:0]  col,
  output logic [1:0]  row,
  output logic        full
);

  logic [BOARD_ROWS-1:0] column;

  always_comb begin
    column[0] = board[{2'd0, col}];
    column[1] = board[{2'd1, col}];
    column[2] = board[{2'd2, col}];
    column[3] = board[{2'd3, col}];
    full      = &column;
    // Row 0 is the bottom, so the first empty cell from below is the landing row.
    if (!column[0])      row = 2'd0;
    else if (!column[1]) row = 2'd1;
    else if (!column[2]) row = 2'd2;
    else                 row = 2'd3;
  end

endmodule

// File: rtl/drop_controller.sv
// rtl/drop_controller.sv - gravity drop, turn alternation and game lock for Connect4
import connect4_defs::*;

module drop_controller #(
  parameter int   EVAL_CYCLES  = 2,
  parameter logic FIRST_PLAYER = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  col_sel,
  input  logic        drop_btn,
  input  logic [1:0]  game_status,
  output logic [15:0] game_board,
  output logic [15:0] player_cells,
  output logic        current_player,
  output logic        move_accept,
  output logic        move_reject,
  output logic        game_over
);

  localparam int CNT_W = (EVAL_CYCLES < 2) ? 1 : $clog2(EVAL_CYCLES + 1);

  drop_state_t      state, state_next;
  logic             btn_q;
  logic             press;
  logic [1:0]       col_q;
  logic [CNT_W-1:0] eval_cnt;
  logic [1:0]       scan_row;
  logic             scan_full;
  logic             eval_done;
  logic             do_accept;
  logic             do_reject;
  logic             toggle_player;
  logic [3:0]       cell_idx;

  column_scan u_column_scan (
    .board (game_board),
    .col   (col_q),
    .row   (scan_row),
    .full  (scan_full)
  );

  assign press     = drop_btn & ~btn_q;
  assign eval_done = (eval_cnt == CNT_W'(1));
  assign cell_idx  = {scan_row, col_q};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:      if (press) state_next = S_DROP;
      S_DROP:      state_next = scan_full ? S_IDLE : S_EVAL;
      S_EVAL:      if (eval_done) state_next = (game_status == ST_PLAY) ? S_IDLE : S_GAME_OVER;
      S_GAME_OVER: state_next = S_GAME_OVER;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    do_accept     = (state == S_DROP) && !scan_full;
    do_reject     = (state == S_DROP) && scan_full;
    toggle_player = (state == S_EVAL) && eval_done && (game_status == ST_PLAY);
    game_over     = (state == S_GAME_OVER);
  end

  // Counter reaches zero on the same edge that samples the verdict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q          <= 1'b0;
      col_q          <= 2'd0;
      eval_cnt       <= '0;
      game_board     <= '0;
      player_cells   <= '0;
      current_player <= FIRST_PLAYER;
      move_accept    <= 1'b0;
      move_reject    <= 1'b0;
    end else begin
      btn_q       <= drop_btn;
      move_accept <= do_accept;
      move_reject <= do_reject;
      if (state == S_IDLE && press) col_q <= col_sel;
      if (do_accept) begin
        game_board[cell_idx]   <= 1'b1;
        player_cells[cell_idx] <= current_player;
        eval_cnt               <= CNT_W'(EVAL_CYCLES);
      end else if (state == S_EVAL) begin
        eval_cnt <= eval_cnt - CNT_W'(1);
      end
      if (toggle_player) current_player <= ~current_player;
    end
  end

endmodule

// File: tb/tb_drop_controller.sv
// tb/tb_drop_controller.sv - randomized and directed bench for drop_controller
module tb_drop_controller;

  localparam int E = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  col_sel = 2'd0;
  logic        drop_btn = 1'b0;
  logic [1:0]  game_status = 2'd0;
  logic [15:0] game_board;
  logic [15:0] player_cells;
  logic        current_player;
  logic        move_accept;
  logic        move_reject;
  logic        game_over;

  drop_controller #(.EVAL_CYCLES(E), .FIRST_PLAYER(1'b0)) dut (
    .clk            (clk),
    .reset          (reset),
    .col_sel        (col_sel),
    .drop_btn       (drop_btn),
    .game_status    (game_status),
    .game_board     (game_board),
    .player_cells   (player_cells),
    .current_player (current_player),
    .move_accept    (move_accept),
    .move_reject    (move_reject),
    .game_over      (game_over)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int rej_cnt = 0;
  bit chk_en = 1'b0;

  // Reference model: column heights plus scheduled edge numbers for pending events.
  logic [15:0] m_board, m_cells;
  logic        m_player, m_over, m_busy, m_btn_prev, m_acc, m_rej;
  int          m_height [4];
  logic [1:0]  m_col;
  int          m_edge = 0;
  int          m_drop_edge, m_eval_edge;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_board = '0; m_cells = '0; m_player = 1'b0; m_over = 1'b0; m_busy = 1'b0;
    m_btn_prev = 1'b0; m_acc = 1'b0; m_rej = 1'b0; m_col = 2'd0;
    m_drop_edge = -1; m_eval_edge = -1;
    for (int i = 0; i < 4; i++) m_height[i] = 0;
  endtask

  task automatic model_step();
    logic       pr, was_idle;
    logic [3:0] idx;
    pr = drop_btn & ~m_btn_prev;
    m_btn_prev = drop_btn;
    was_idle = !m_busy && !m_over;
    m_acc = 1'b0;
    m_rej = 1'b0;
    if (m_edge == m_drop_edge) begin
      m_drop_edge = -1;
      if (m_height[m_col] == 4) begin
        m_rej = 1'b1;
        m_busy = 1'b0;
      end else begin
        idx = 4'(m_height[m_col] * 4 + int'(m_col));
        m_board[idx] = 1'b1;
        m_cells[idx] = m_player;
        m_height[m_col] = m_height[m_col] + 1;
        m_acc = 1'b1;
        m_eval_edge = m_edge + E;
      end
    end else if (m_edge == m_eval_edge) begin
      m_eval_edge = -1;
      if (game_status == 2'b00) begin
        m_player = ~m_player;
        m_busy = 1'b0;
      end else begin
        m_over = 1'b1;
      end
    end
    if (was_idle && pr) begin
      m_busy = 1'b1;
      m_drop_edge = m_edge + 1;
      m_col = col_sel;
    end
    m_edge++;
  endtask

  always @(posedge clk) if (!reset) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("board", 32'(game_board), 32'(m_board));
      check("cells", 32'(player_cells & m_board), 32'(m_cells & m_board));
      check("player", 32'(current_player), 32'(m_player));
      check("accept", 32'(move_accept), 32'(m_acc));
      check("reject", 32'(move_reject), 32'(m_rej));
      check("over", 32'(game_over), 32'(m_over));
      if (move_accept) acc_cnt++;
      if (move_reject) rej_cnt++;
    end
  end

  task automatic apply_reset();
    @(negedge clk); #1;
    reset = 1'b1; drop_btn = 1'b0; game_status = 2'b00;
    model_reset();
    @(negedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic do_press(input logic [1:0] c);
    @(negedge clk); #1;
    col_sel = c; drop_btn = 1'b1;
    @(negedge clk); #1;
    drop_btn = 1'b0;
    repeat (E + 3) @(negedge clk);
  endtask

  logic [15:0] exp_b1 [4];
  logic [15:0] exp_c1 [4];
  logic        exp_p1 [4];
  int a0, r0;

  initial begin
    exp_b1 = '{16'h0001, 16'h0011, 16'h0111, 16'h1111};
    exp_c1 = '{16'h0000, 16'h0010, 16'h0010, 16'h1010};
    exp_p1 = '{1'b1, 1'b0, 1'b1, 1'b0};
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_board", 32'(game_board), 32'h0);
    check("rst_cells", 32'(player_cells), 32'h0);
    check("rst_player", 32'(current_player), 32'h0);
    check("rst_flags", 32'({move_accept, move_reject, game_over}), 32'h0);
    chk_en = 1'b1;
    #1 reset = 1'b0;

    // Stacking four pieces in column 0
    for (int i = 0; i < 4; i++) begin
      do_press(2'd0);
      check("c1_board", 32'(game_board), 32'(exp_b1[i]));
      check("c1_cells", 32'(player_cells), 32'(exp_c1[i]));
      check("c1_player", 32'(current_player), 32'(exp_p1[i]));
    end

    // Full column rejection
    apply_reset();
    for (int i = 0; i < 4; i++) do_press(2'd2);
    r0 = rej_cnt; a0 = acc_cnt;
    do_press(2'd2);
    check("c2_rejects", 32'(rej_cnt - r0), 32'd1);
    check("c2_accepts", 32'(acc_cnt - a0), 32'd0);
    check("c2_board", 32'(game_board), 32'h4444);
    check("c2_player", 32'(current_player), 32'h0);

    // Win verdict locks the board
    apply_reset();
    game_status = 2'b01;
    do_press(2'd1);
    check("c3_over", 32'(game_over), 32'h1);
    a0 = acc_cnt;
    game_status = 2'b00;
    do_press(2'd0);
    do_press(2'd3);
    check("c3_board", 32'(game_board), 32'h0002);
    check("c3_accepts", 32'(acc_cnt - a0), 32'd0);
    check("c3_over_held", 32'(game_over), 32'h1);

    // Held button and a second edge during evaluation
    apply_reset();
    a0 = acc_cnt;
    @(negedge clk); #1;
    col_sel = 2'd0; drop_btn = 1'b1;
    repeat (10) @(negedge clk);
    #1 drop_btn = 1'b0;
    repeat (E + 3) @(negedge clk);
    check("c4_accepts", 32'(acc_cnt - a0), 32'd1);
    check("c4_board", 32'(game_board), 32'h0001);
    @(negedge clk); #1;
    col_sel = 2'd1; drop_btn = 1'b1;
    @(negedge clk); #1 drop_btn = 1'b0;
    @(negedge clk); #1 drop_btn = 1'b1;
    @(negedge clk); #1 drop_btn = 1'b0;
    repeat (E + 4) @(negedge clk);
    check("c4_accepts2", 32'(acc_cnt - a0), 32'd2);
    check("c4_board2", 32'(game_board), 32'h0003);

    // Reset one cycle after an accepted move
    apply_reset();
    @(negedge clk); #1;
    col_sel = 2'd0; drop_btn = 1'b1;
    @(negedge clk); #1 drop_btn = 1'b0;
    @(negedge clk);
    check("c5_pulse", 32'(move_accept), 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    model_reset();
    #1;
    check("c5_board", 32'(game_board), 32'h0);
    check("c5_cells", 32'(player_cells), 32'h0);
    check("c5_outs", 32'({current_player, move_accept, move_reject, game_over}), 32'h0);
    @(negedge clk); #1 reset = 1'b0;
    do_press(2'd3);
    check("c5_next", 32'(game_board), 32'h0008);

    // Full board ending in a tie verdict
    apply_reset();
    for (int i = 0; i < 15; i++) do_press(2'(i % 4));
    game_status = 2'b11;
    do_press(2'd3);
    check("c6_over", 32'(game_over), 32'h1);
    check("c6_board", 32'(game_board), 32'hFFFF);
    check("c6_cells", 32'(player_cells), 32'hAAAA);
    check("c6_player", 32'(current_player), 32'h1);

    // Randomized play against the model, with occasional resets
    apply_reset();
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk); #1;
      if ((m_over && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0) begin
        reset = 1'b1;
        drop_btn = 1'b0;
        model_reset();
        @(negedge clk); #1;
        reset = 1'b0;
      end
      drop_btn = ($urandom_range(0, 2) == 0);
      col_sel = 2'($urandom_range(0, 3));
      game_status = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    end
    @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
